// File: rtl/branch_predictor.sv
// Dynamic branch predictor: 2-bit saturating-counter PHT plus direct-mapped BTB,
// looked up combinationally from IF and trained from MEM, with perf counters.
module branch_predictor #(
  parameter int          IDX_BITS = 6,
  parameter int          GHR_BITS = 4,
  parameter int          MODE     = 0,
  parameter logic [1:0]  CTR_INIT = 2'b01,
  parameter int          CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic [31:0]         if_pc,
  output logic                pred_taken,
  output logic [31:0]         pred_target,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                res_valid,
  input  logic                res_is_br,
  input  logic                res_is_jump,
  input  logic [31:0]         res_pc,
  input  logic                res_taken,
  input  logic [31:0]         res_target,
  input  logic                res_pred_taken,
  input  logic [31:0]         res_pred_target,
  input  logic [GHR_BITS-1:0] res_ghr,
  output logic                res_mispredict,
  output logic [31:0]         redirect_pc,
  output logic [CNT_W-1:0]    br_count,
  output logic [CNT_W-1:0]    mispred_count
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 30 - IDX_BITS;

  logic [1:0]          pht        [ENTRIES];
  logic                btb_valid  [ENTRIES];
  logic [TAG_W-1:0]    btb_tag    [ENTRIES];
  logic [31:0]         btb_target [ENTRIES];
  logic                btb_jump   [ENTRIES];
  logic [GHR_BITS-1:0] ghr;

  // PC bits [1:0] are always zero for RV32I without compressed instructions.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], res_pc[1:0]};

  // Lookup side
  logic [IDX_BITS-1:0] bidx, pidx, ghr_ext;
  logic [TAG_W-1:0]    ltag;
  logic                btb_hit;

  assign ghr_ext     = IDX_BITS'(ghr);
  assign bidx        = if_pc[IDX_BITS+1:2];
  assign ltag        = if_pc[31:IDX_BITS+2];
  assign pidx        = (MODE == 1) ? (bidx ^ ghr_ext) : bidx;
  assign btb_hit     = btb_valid[bidx] && (btb_tag[bidx] == ltag);
  assign pred_taken  = btb_hit && (btb_jump[bidx] || pht[pidx][1]);
  assign pred_target = pred_taken ? btb_target[bidx] : (if_pc + 32'd4);
  assign pred_ghr    = ghr;

  // Resolve side. res_valid is a one-cycle qualifier with no ready: an update is
  // consumed on any clock edge where res_valid is high and stall is low.
  logic                is_jump, is_br, upd;
  logic [IDX_BITS-1:0] ubidx, upidx, res_ghr_ext;
  logic [GHR_BITS:0]   ghr_shift;

  assign is_jump        = res_is_jump;
  assign is_br          = res_is_br && !res_is_jump;
  assign res_mispredict = res_valid && (res_is_br || res_is_jump) &&
                          ((res_taken != res_pred_taken) ||
                           (res_taken && (res_target != res_pred_target)));
  assign redirect_pc    = res_taken ? res_target : (res_pc + 32'd4);
  assign upd            = res_valid && !stall && (res_is_br || res_is_jump);
  assign res_ghr_ext    = IDX_BITS'(res_ghr);
  assign ubidx          = res_pc[IDX_BITS+1:2];
  assign upidx          = (MODE == 1) ? (ubidx ^ res_ghr_ext) : ubidx;
  // Extra bit keeps the shift legal for GHR_BITS == 1.
  assign ghr_shift      = {ghr, res_taken};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht[i]        <= CTR_INIT;
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_jump[i]   <= 1'b0;
      end
      ghr <= '0;
    end else if (upd) begin
      if (is_br) begin
        if (res_taken && (pht[upidx] != 2'b11))
          pht[upidx] <= pht[upidx] + 2'd1;
        else if (!res_taken && (pht[upidx] != 2'b00))
          pht[upidx] <= pht[upidx] - 2'd1;
        ghr <= ghr_shift[GHR_BITS-1:0];
      end
      if (res_taken) begin
        btb_valid[ubidx]  <= 1'b1;
        btb_tag[ubidx]    <= res_pc[31:IDX_BITS+2];
        btb_target[ubidx] <= res_target;
        btb_jump[ubidx]   <= is_jump;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (upd) begin
      if (br_count != '1)
        br_count <= br_count + 1'b1;
      if (res_mispredict && (mispred_count != '1))
        mispred_count <= mispred_count + 1'b1;
    end
  end

  a_br_jump_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(res_valid && res_is_br && res_is_jump));

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: bimodal and gshare instances share stimulus;
// expected values are queued by drivers and checked by a negedge monitor.
module tb_branch_predictor;
  logic        clk, rst, stall;
  logic [31:0] if_pc;
  logic        res_valid, res_is_br, res_is_jump, res_taken, res_pred_taken;
  logic [31:0] res_pc, res_target, res_pred_target;
  logic [3:0]  res_ghr;

  logic        b_taken, b_mis, g_taken, g_mis;
  logic [31:0] b_target, b_redir, b_br, b_misc, g_target, g_redir, g_br, g_misc;
  logic [3:0]  b_ghr, g_ghr;

  branch_predictor #(.IDX_BITS(6), .GHR_BITS(4), .MODE(0)) u_bim (
    .clk(clk), .rst(rst), .stall(stall), .if_pc(if_pc),
    .pred_taken(b_taken), .pred_target(b_target), .pred_ghr(b_ghr),
    .res_valid(res_valid), .res_is_br(res_is_br), .res_is_jump(res_is_jump),
    .res_pc(res_pc), .res_taken(res_taken), .res_target(res_target),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
    .res_ghr(res_ghr), .res_mispredict(b_mis), .redirect_pc(b_redir),
    .br_count(b_br), .mispred_count(b_misc));

  branch_predictor #(.IDX_BITS(6), .GHR_BITS(4), .MODE(1)) u_gsh (
    .clk(clk), .rst(rst), .stall(stall), .if_pc(if_pc),
    .pred_taken(g_taken), .pred_target(g_target), .pred_ghr(g_ghr),
    .res_valid(res_valid), .res_is_br(res_is_br), .res_is_jump(res_is_jump),
    .res_pc(res_pc), .res_taken(res_taken), .res_target(res_target),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
    .res_ghr(res_ghr), .res_mispredict(g_mis), .redirect_pc(g_redir),
    .br_count(g_br), .mispred_count(g_misc));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  localparam int K_TAKEN = 0, K_TARGET = 1, K_MIS = 2, K_RED = 3, K_BR = 4,
                 K_MISC = 5, K_GTAKEN = 6, K_GTARGET = 7, K_GGHR = 8;
  logic [31:0] exp_q[$];
  int          kind_q[$];
  string       name_q[$];
  int          total = 0, bad = 0;
  logic [31:0] mon_exp, mon_act;
  int          mon_kind;
  string       mon_name;

  task automatic expect_v(input int k, input logic [31:0] v, input string nm);
    exp_q.push_back(v);
    kind_q.push_back(k);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_kind = kind_q.pop_front();
      mon_name = name_q.pop_front();
      case (mon_kind)
        K_TAKEN:   mon_act = {31'd0, b_taken};
        K_TARGET:  mon_act = b_target;
        K_MIS:     mon_act = {31'd0, b_mis};
        K_RED:     mon_act = b_redir;
        K_BR:      mon_act = b_br;
        K_MISC:    mon_act = b_misc;
        K_GTAKEN:  mon_act = {31'd0, g_taken};
        K_GTARGET: mon_act = g_target;
        default:   mon_act = {28'd0, g_ghr};
      endcase
      total++;
      if (mon_act !== mon_exp) begin
        bad++;
        $display("FAIL %s: got %h want %h (t=%0t)", mon_name, mon_act, mon_exp, $time);
      end
    end
  end

  // driver tasks
  task automatic lookup(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                        input bit gsh);
    @(posedge clk); #1;
    if_pc = pc;
    expect_v(gsh ? K_GTAKEN : K_TAKEN, {31'd0, tk}, gsh ? "g_pred_taken" : "pred_taken");
    expect_v(gsh ? K_GTARGET : K_TARGET, tgt, gsh ? "g_pred_target" : "pred_target");
  endtask

  task automatic counts(input logic [31:0] br, input logic [31:0] mis);
    @(posedge clk); #1;
    expect_v(K_BR, br, "br_count");
    expect_v(K_MISC, mis, "mispred_count");
  endtask

  task automatic set_res(input logic [31:0] pc, input bit br, input bit jmp, input bit tk,
                         input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt,
                         input logic [3:0] gh);
    res_valid = 1'b1; res_pc = pc; res_is_br = br; res_is_jump = jmp;
    res_taken = tk; res_target = tgt; res_pred_taken = ptk;
    res_pred_target = ptgt; res_ghr = gh;
  endtask

  task automatic resolve(input logic [31:0] pc, input bit br, input bit jmp, input bit tk,
                         input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt,
                         input logic [3:0] gh, input bit exp_mis,
                         input logic [31:0] exp_red);
    @(posedge clk); #1;
    set_res(pc, br, jmp, tk, tgt, ptk, ptgt, gh);
    expect_v(K_MIS, {31'd0, exp_mis}, "res_mispredict");
    expect_v(K_RED, exp_red, "redirect_pc");
    @(posedge clk); #1;
    res_valid = 1'b0;
  endtask

  task automatic expect_ghr(input logic [3:0] v);
    @(posedge clk); #1;
    expect_v(K_GGHR, {28'd0, v}, "g_pred_ghr");
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; if_pc = 32'h100;
    res_valid = 1'b0; res_is_br = 1'b0; res_is_jump = 1'b0; res_pc = '0;
    res_taken = 1'b0; res_target = '0; res_pred_taken = 1'b0;
    res_pred_target = '0; res_ghr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // ---- bimodal: reset state
    lookup(32'h100, 0, 32'h104, 0);
    counts(0, 0);
    @(posedge clk); #1;
    expect_v(K_MIS, 32'd0, "res_mispredict_idle");

    // first taken branch: mispredict, then BTB/PHT hit
    resolve(32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 4'h0, 1, 32'h80);
    lookup(32'h100, 1, 32'h80, 0);
    counts(1, 1);

    // saturate at 11, then walk down to 01
    repeat (3) resolve(32'h100, 1, 0, 1, 32'h80, 1, 32'h80, 4'h0, 0, 32'h80);
    counts(4, 1);
    resolve(32'h100, 1, 0, 0, 32'h80, 1, 32'h80, 4'h0, 1, 32'h104);
    lookup(32'h100, 1, 32'h80, 0);
    resolve(32'h100, 1, 0, 0, 32'h80, 1, 32'h80, 4'h0, 1, 32'h104);
    lookup(32'h100, 0, 32'h104, 0);
    counts(6, 3);

    // alias: 0x200 shares index 0 with a different tag
    resolve(32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 4'h0, 1, 32'h80);
    lookup(32'h100, 1, 32'h80, 0);
    lookup(32'h200, 0, 32'h204, 0);
    resolve(32'h200, 1, 0, 1, 32'h300, 0, 32'h204, 4'h0, 1, 32'h300);
    lookup(32'h100, 0, 32'h104, 0);
    lookup(32'h200, 1, 32'h300, 0);
    counts(8, 5);

    // jumps predict taken regardless of the 01 counter
    resolve(32'h40, 0, 1, 1, 32'h1000, 0, 32'h44, 4'h0, 1, 32'h1000);
    lookup(32'h40, 1, 32'h1000, 0);
    resolve(32'h40, 0, 1, 1, 32'h1000, 1, 32'h1004, 4'h0, 1, 32'h1000);
    resolve(32'h40, 0, 1, 1, 32'h1000, 1, 32'h1000, 4'h0, 0, 32'h1000);
    counts(11, 7);

    // res_valid with neither flag: no mispredict, no count
    resolve(32'h500, 0, 0, 0, 32'h900, 1, 32'h900, 4'h0, 0, 32'h504);
    counts(11, 7);

    // stall holds all state for three edges
    @(posedge clk); #1;
    stall = 1'b1;
    if_pc = 32'h300;
    set_res(32'h300, 1, 0, 1, 32'h700, 0, 32'h304, 4'h0);
    repeat (3) begin
      expect_v(K_BR, 32'd11, "br_count_stalled");
      expect_v(K_MIS, 32'd1, "res_mispredict_stalled");
      expect_v(K_TAKEN, 32'd0, "pred_taken_stalled");
      @(posedge clk); #1;
    end
    stall = 1'b0;
    @(posedge clk); #1;
    res_valid = 1'b0;
    counts(12, 8);
    lookup(32'h300, 1, 32'h700, 0);

    // asynchronous reset between edges
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    expect_v(K_BR, 32'd0, "br_count_async_rst");
    expect_v(K_MISC, 32'd0, "mispred_count_async_rst");
    expect_v(K_TAKEN, 32'd0, "pred_taken_async_rst");
    expect_v(K_TARGET, 32'h304, "pred_target_async_rst");
    @(posedge clk); #1;
    rst = 1'b0;

    // ---- gshare
    expect_ghr(4'h0);
    resolve(32'h50, 1, 0, 1, 32'h60, 0, 32'h54, 4'h0, 1, 32'h60);
    expect_ghr(4'h1);
    resolve(32'h50, 1, 0, 1, 32'h60, 0, 32'h54, 4'h1, 1, 32'h60);
    resolve(32'h50, 1, 0, 1, 32'h60, 0, 32'h54, 4'h3, 1, 32'h60);
    resolve(32'h50, 1, 0, 1, 32'h60, 0, 32'h54, 4'h7, 1, 32'h60);
    expect_ghr(4'hF);
    // 0x100 with GHR=F trains entry 0x0F; lookup under GHR=F must see it
    resolve(32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 4'hF, 1, 32'h80);
    lookup(32'h100, 1, 32'h80, 1);
    resolve(32'h50, 1, 0, 0, 32'h60, 0, 32'h54, 4'hF, 0, 32'h54);
    expect_ghr(4'hE);
    resolve(32'h40, 0, 1, 1, 32'h1000, 0, 32'h44, 4'hE, 1, 32'h1000);
    expect_ghr(4'hE);
    // GHR=E selects untouched entry 0x0E
    lookup(32'h100, 0, 32'h104, 1);

    repeat (2) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage RV32I pipeline. It replaces static predict-not-taken with a PHT of 2-bit saturating counters plus a direct-mapped BTB.
- IF stage looks it up combinationally each cycle, using the PC being fetched.
- MEM stage, where branches and jumps resolve, trains it and receives a mispredict flag and redirect PC.
- Supports bimodal or gshare indexing and keeps saturating performance counters.

Parameters:
- IDX_BITS, 6, log2 of PHT/BTB entries (PC bits [IDX_BITS+1:2] form the index).
- GHR_BITS, 4, global history length; legal range 1..IDX_BITS.
- MODE, 0, 0 = bimodal (PC index); 1 = gshare (PC index XOR zero-extended GHR).
- CTR_INIT, 2'b01, reset value of every PHT counter (weakly not-taken).
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- stall  in  1  1 = hold all state (driven by the pipeline's inverted load-enable)
- if_pc  in  32  PC being fetched
- pred_taken  out  1  predicted taken
- pred_target  out  32  predicted next PC
- pred_ghr  out  GHR_BITS  current GHR; the pipeline carries it to MEM
- res_valid  in  1  MEM stage holds a resolved control-flow instruction
- res_is_br  in  1  conditional branch
- res_is_jump  in  1  jal/jalr
- res_pc  in  32  PC of resolving instruction
- res_taken  in  1  actual outcome (1 for jumps)
- res_target  in  32  actual taken target
- res_pred_taken  in  1  prediction carried down the pipe
- res_pred_target  in  32  predicted target carried down the pipe
- res_ghr  in  GHR_BITS  pred_ghr carried down the pipe
- res_mispredict  out  1  redirect required
- redirect_pc  out  32  correct next PC
- br_count  out  CNT_W  resolved control-flow instructions
- mispred_count  out  CNT_W  mispredictions

Behaviour:
- Reset:
  - rst is asynchronous and active-high; it takes effect immediately, mid-operation included.
  - Clears all BTB valid bits, the GHR and both performance counters.
  - Sets every PHT counter to CTR_INIT.
  - After reset: pred_taken=0, pred_target=if_pc+4, res_mispredict=0 unless res_valid.
- Lookup (combinational, zero latency):
  - bidx = if_pc[IDX_BITS+1:2]; tag = if_pc[31:IDX_BITS+2].
  - pidx = bidx when MODE=0; pidx = bidx ^ GHR (zero-extended) when MODE=1.
  - btb_hit = valid[bidx] && tag match.
  - pred_taken = btb_hit && (jump_bit[bidx] || pht[pidx][1]).
  - pred_target = pred_taken ? btb_target[bidx] : if_pc+4.
- Resolve (combinational):
  - res_mispredict = res_valid && (res_is_br||res_is_jump) && (res_taken != res_pred_taken || (res_taken && res_target != res_pred_target)).
  - redirect_pc = res_taken ? res_target : res_pc+4.
  - Neither output is gated by stall; the consumer qualifies it.
- Update: on posedge clk when upd = res_valid && !stall && (res_is_br||res_is_jump). The update index uses res_pc, plus res_ghr when MODE=1.
  - PHT, only if res_is_br: saturating increment on taken, decrement on not-taken. Stays at 11 on taken and at 00 on not-taken.
  - BTB, only if res_taken: write valid=1, tag, target=res_target, jump_bit=res_is_jump. This overwrites any alias. Not-taken leaves the entry untouched.
  - GHR, only if res_is_br: GHR <= {GHR[GHR_BITS-2:0], res_taken}. Jumps do not shift it. The GHR is non-speculative and is maintained in both modes.
  - br_count += 1 on upd; mispred_count += 1 when upd && res_mispredict. Both saturate at all-ones.
- Same-cycle lookup and update of the same entry: the lookup returns the pre-update value (no bypass).
- res_is_br && res_is_jump both high is illegal: assert in simulation; treat as jump.
- res_valid with neither flag set: no update, res_mispredict=0.

Test Plan:
- MODE=0, reset, lookup if_pc=0x100 -> pred_taken=0, pred_target=0x104. Resolve branch pc=0x100 taken target=0x80 with res_pred_taken=0 -> res_mispredict=1, redirect_pc=0x80. Next cycle lookup 0x100 -> pred_taken=1, pred_target=0x80. br_count=1, mispred_count=1.
- Train 0x100 taken 3 times (counter saturates at 11), then not-taken once -> still predicts taken (10). Not-taken again -> 01, pred_taken=0. On the not-taken resolve with res_pred_taken=1: redirect_pc=0x104.
- Alias check: after 0x100 is trained, lookup 0x200 (same index, different tag) -> btb_hit=0, pred_taken=0. Resolve 0x200 taken to 0x300 -> lookup 0x100 now misses.
- Jump: resolve jal pc=0x40 target=0x1000 once -> lookup 0x40 gives pred_taken=1, 0x1000 with counter at 01. Target mismatch (pred 0x1004, actual 0x1000) -> res_mispredict=1.
- MODE=1, GHR_BITS=4: four taken branches -> pred_ghr=4'hF. Branch at 0x100 trains PHT index 0x0F, not 0x00. A jump resolve leaves the GHR unchanged.
- stall=1 with res_valid=1 for 3 cycles -> no table or counter change. Release -> br_count increments exactly once. Assert rst between clock edges -> btb_hit=0 and both performance counters read 0 immediately.
